// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D} arb_state_t;
  typedef enum logic {REQ_I, REQ_D} req_id_t;

  localparam int unsigned ADDR_W_DEF      = 16;
  localparam int unsigned DATA_W_DEF      = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  function automatic arb_state_t serve_state(input req_id_t id);
    return (id == REQ_I) ? ARB_SERVE_I : ARB_SERVE_D;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on contention the side that did not win last time is chosen.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  req_id_t last_gnt,
  output req_id_t gnt,
  output logic    gnt_vld
);

  always_comb begin
    gnt_vld = i_req | d_req;
    gnt     = REQ_D;
    if (i_req && d_req) begin
      gnt = (last_gnt == REQ_I) ? REQ_D : REQ_I;
    end else if (i_req) begin
      gnt = REQ_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D); round-robin, one transaction in flight.
// Optional ack timeout abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_done_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_done_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  arb_state_t        state_q, state_d;
  req_id_t           last_q, last_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;
  req_id_t           pick;
  logic              pick_vld;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYC - 1);
  logic [TMR_W-1:0] timer_q, timer_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  rr_pick2 u_pick (
    .i_req    (i_req_i),
    .d_req    (d_req_i),
    .last_gnt (last_q),
    .gnt      (pick),
    .gnt_vld  (pick_vld)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    timer_d     = timer_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_d   = serve_state(pick);
          last_d    = pick;
          mem_req_d = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          timer_d   = '0;
`endif
          if (pick == REQ_I) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr_i;
            mem_wdata_d = '0;
          end else begin
            mem_we_d    = d_we_i;
            mem_addr_d  = d_addr_i;
            mem_wdata_d = d_wdata_i;
          end
        end
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        if (mem_ack_i) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
          if (state_q == ARB_SERVE_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = mem_rdata_i;
          end else begin
            d_done_d = 1'b1;
            // Stores complete without touching the load data register.
            if (!mem_we_q) d_rdata_d = mem_rdata_i;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (timer_q == TMR_LIMIT) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == ARB_SERVE_I) i_done_d = 1'b1;
          else                        d_done_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ARB_IDLE;
      last_q      <= REQ_D;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
`ifdef MEM_ARB_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign i_done_o    = i_done_q;
  assign d_done_o    = d_done_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences, random vs model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif
  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        i_req_i = 1'b0;
  logic [15:0] i_addr_i = '0;
  logic        i_done_o;
  logic [15:0] i_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [15:0] d_addr_i = '0;
  logic [15:0] d_wdata_i = '0;
  logic        d_done_o;
  logic [15:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [15:0] mem_rdata_i = '0;
  logic        err_o;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_done_o(i_done_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_done_o(d_done_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  function automatic logic [79:0] all_outs();
    return {11'd0, i_done_o, i_rdata_o, d_done_o, d_rdata_o, mem_req_o, mem_we_o,
            mem_addr_o, mem_wdata_o, err_o};
  endfunction

  task automatic clear_inputs();
    i_req_i = 0; i_addr_i = '0; d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0;
    mem_ack_i = 0; mem_rdata_i = '0;
  endtask

  // Called on a falling edge: one cycle of reset, outputs must clear asynchronously.
  task automatic do_reset(input string name);
    rst_n_i = 1'b0;
    #1;
    chk(name, all_outs(), 80'd0);
    step();
    rst_n_i = 1'b1;
  endtask

  // Transaction-level reference: who owns the port, who won last, how long it has waited.
  int          m_owner;   // 0 none, 1 fetch, 2 data
  bit          m_last_i;
  int          m_wait;
  logic        e_mreq, e_mwe, e_idone, e_ddone, e_err;
  logic [15:0] e_maddr, e_mwdata, e_irdata, e_drdata;

  task automatic model_reset();
    m_owner = 0; m_last_i = 0; m_wait = 0;
    e_mreq = 0; e_mwe = 0; e_idone = 0; e_ddone = 0; e_err = 0;
    e_maddr = '0; e_mwdata = '0; e_irdata = '0; e_drdata = '0;
  endtask

  task automatic model_step();
    int who;
    e_idone = 0; e_ddone = 0; e_err = 0;
    if (m_owner == 0) begin
      who = 0;
      if (i_req_i && d_req_i) who = m_last_i ? 2 : 1;
      else if (i_req_i)       who = 1;
      else if (d_req_i)       who = 2;
      if (who != 0) begin
        m_owner = who; m_last_i = (who == 1); m_wait = 0; e_mreq = 1;
        e_mwe    = (who == 2) ? d_we_i : 1'b0;
        e_maddr  = (who == 2) ? d_addr_i : i_addr_i;
        e_mwdata = (who == 2) ? d_wdata_i : 16'h0;
      end
    end else if (mem_ack_i) begin
      if (m_owner == 1) begin
        e_idone = 1; e_irdata = mem_rdata_i;
      end else begin
        e_ddone = 1;
        if (!e_mwe) e_drdata = mem_rdata_i;
      end
      e_mreq = 0; m_owner = 0;
    end else begin
      m_wait++;
      if (TIMEOUT_ON && m_wait == TO) begin
        e_err = 1; e_mreq = 0;
        if (m_owner == 1) e_idone = 1; else e_ddone = 1;
        m_owner = 0;
      end
    end
  endtask

  typedef struct {
    logic ir; logic [15:0] ia; logic dr; logic dw; logic [15:0] da; logic [15:0] dwd;
    logic ak; logic [15:0] rd;
    logic em; logic ew; logic [15:0] ea; logic [15:0] ewd;
    logic eid; logic edd; logic [15:0] eir; logic [15:0] edr;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                              input logic [15:0] da, input logic [15:0] dwd, input logic ak,
                              input logic [15:0] rd, input logic em, input logic ew,
                              input logic [15:0] ea, input logic [15:0] ewd, input logic eid,
                              input logic edd, input logic [15:0] eir, input logic [15:0] edr);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.ak = ak; v.rd = rd;
    v.em = em; v.ew = ew; v.ea = ea; v.ewd = ewd; v.eid = eid; v.edd = edd; v.eir = eir; v.edr = edr;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    logic [15:0] order[4];
    int          gaps[3];
    int          grants, hi, lo, cyc;

    tbl[0]  = mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    tbl[1]  = mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 0, 0, 16'h0010, 16'h0000, 1, 0, 16'h1234, 16'h0000);
    tbl[2]  = mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h1234, 16'h0000);
    tbl[3]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'h5678, 0, 0, 16'h0010, 16'h0000, 1, 0, 16'h5678, 16'h0000);
    tbl[4]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'hDEAD, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h5678, 16'h0000);
    tbl[5]  = mk(0, 16'h0000, 1, 1, 16'h0040, 16'hBEEF, 0, 16'h0000, 1, 1, 16'h0040, 16'hBEEF, 0, 0, 16'h5678, 16'h0000);
    for (int k = 6; k < 10; k++)
      tbl[k] = mk(0, 16'h0000, 1, 1, 16'h0040, 16'hBEEF, 0, 16'h0000, 1, 1, 16'h0040, 16'hBEEF, 0, 0, 16'h5678, 16'h0000);
    tbl[10] = mk(0, 16'h0000, 1, 1, 16'h0040, 16'hBEEF, 1, 16'h1111, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h5678, 16'h0000);
    tbl[11] = mk(1, 16'h0020, 1, 0, 16'h0030, 16'h7777, 0, 16'h0000, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'h5678, 16'h0000);
    tbl[12] = mk(1, 16'h0020, 1, 0, 16'h0030, 16'h7777, 1, 16'hAAAA, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'hAAAA, 16'h0000);
    tbl[13] = mk(1, 16'h0020, 1, 0, 16'h0030, 16'h7777, 0, 16'h0000, 1, 0, 16'h0030, 16'h7777, 0, 0, 16'hAAAA, 16'h0000);
    tbl[14] = mk(1, 16'h0020, 1, 0, 16'h0030, 16'h7777, 1, 16'hBBBB, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hAAAA, 16'hBBBB);

    #1 rst_n_i = 1'b0;
    #1 chk("reset_outputs", all_outs(), 80'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Directed vector table: fetch same-cycle ack, stray ack, delayed store, contention.
    foreach (tbl[k]) begin
      i_req_i = tbl[k].ir; i_addr_i = tbl[k].ia; d_req_i = tbl[k].dr; d_we_i = tbl[k].dw;
      d_addr_i = tbl[k].da; d_wdata_i = tbl[k].dwd; mem_ack_i = tbl[k].ak; mem_rdata_i = tbl[k].rd;
      step();
      chk($sformatf("tbl%0d_ctl", k), {i_done_o, d_done_o, mem_req_o, err_o},
          {tbl[k].eid, tbl[k].edd, tbl[k].em, 1'b0});
      chk($sformatf("tbl%0d_rdata", k), {i_rdata_o, d_rdata_o}, {tbl[k].eir, tbl[k].edr});
      if (tbl[k].em)
        chk($sformatf("tbl%0d_mem", k), {mem_we_o, mem_addr_o, mem_wdata_o},
            {tbl[k].ew, tbl[k].ea, tbl[k].ewd});
    end
    clear_inputs();

    // Reset while serving a fetch, then contention must favour fetch again.
    i_req_i = 1; i_addr_i = 16'h0055;
    step();
    chk("pre_reset_serving", mem_req_o, 1'b1);
    i_req_i = 0;
    do_reset("reset_mid_serve");
    i_req_i = 1; i_addr_i = 16'h0077; d_req_i = 1; d_addr_i = 16'h0088;
    step();
    chk("post_reset_grant", {i_done_o, d_done_o, mem_req_o, mem_addr_o}, {1'b0, 1'b0, 1'b1, 16'h0077});
    clear_inputs();

    // Back-to-back contention: ack in second cycle of each request, expect I,D,I,D with one bubble.
    do_reset("reset_burst");
    i_req_i = 1; i_addr_i = 16'h0100; d_req_i = 1; d_addr_i = 16'h0200;
    grants = 0; hi = 0; lo = 0; cyc = 0;
    foreach (order[k]) order[k] = '0;
    foreach (gaps[k]) gaps[k] = -1;
    while (grants < 4 && cyc < 60) begin
      if (mem_req_o) begin
        hi++;
        if (hi == 1) begin
          order[grants] = mem_addr_o;
          if (grants > 0) gaps[grants-1] = lo;
          grants++;
        end
        lo = 0;
      end else begin
        hi = 0;
        lo++;
      end
      mem_ack_i = mem_req_o && (hi == 2);
      mem_rdata_i = $urandom_range(0, 16'hFFFF);
      if (grants < 4) step();
      cyc++;
    end
    chk("burst_grant_count", grants, 4);
    chk("burst_order", {order[0], order[1], order[2], order[3]}, {16'h0100, 16'h0200, 16'h0100, 16'h0200});
    foreach (gaps[k]) chk($sformatf("burst_bubble%0d", k), gaps[k], 1);
    clear_inputs();

`ifdef MEM_ARB_TIMEOUT_EN
    // No ack: abort after TO cycles of mem_req with err and done together.
    do_reset("reset_timeout");
    d_req_i = 1; d_addr_i = 16'h0ABC;
    step();
    d_req_i = 0;
    hi = 0; cyc = 0;
    while (!err_o && cyc < 40) begin
      if (mem_req_o) hi++;
      step();
      cyc++;
    end
    chk("timeout_pulse", {err_o, d_done_o, i_done_o, mem_req_o}, {1'b1, 1'b1, 1'b0, 1'b0});
    chk("timeout_len", hi, TO);
    chk("timeout_rdata", d_rdata_o, 16'h0000);
    i_req_i = 1; i_addr_i = 16'h0321;
    step();
    chk("timeout_then_idle", {mem_req_o, err_o, mem_addr_o}, {1'b1, 1'b0, 16'h0321});
    i_req_i = 0;
    for (int k = 1; k < TO; k++) step();
    mem_ack_i = 1; mem_rdata_i = 16'h4242;
    step();
    chk("ack_at_limit_wins", {err_o, i_done_o, i_rdata_o}, {1'b0, 1'b1, 16'h4242});
    clear_inputs();
`endif

    // Random traffic against the reference model.
    do_reset("reset_random");
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      i_req_i = ($urandom_range(0, 3) != 0);
      d_req_i = ($urandom_range(0, 2) != 0);
      d_we_i = $urandom_range(0, 1);
      i_addr_i = $urandom_range(0, 16'hFFFF);
      d_addr_i = $urandom_range(0, 16'hFFFF);
      d_wdata_i = $urandom_range(0, 16'hFFFF);
      mem_rdata_i = $urandom_range(0, 16'hFFFF);
      mem_ack_i = (m_owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      model_step();
      step();
      chk("rand_ctl", {i_done_o, d_done_o, mem_req_o, err_o}, {e_idone, e_ddone, e_mreq, e_err});
      chk("rand_rdata", {i_rdata_o, d_rdata_o}, {e_irdata, e_drdata});
      chk("rand_done_excl", i_done_o & d_done_o, 1'b0);
      if (e_mreq)
        chk("rand_mem", {mem_we_o, mem_addr_o, mem_wdata_o}, {e_mwe, e_maddr, e_mwdata});
    end
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected test to finish");
    $fatal(1, "watchdog");
  end

endmodule
